// File: rtl/noise_map_pkg.sv
// Shared definitions for the noise-selection map transmit path.
//   NOISE_W          width of a noise-select code
//   NOISE_PARK_CODE  idle/park code; matches the map core's reset value
//   nmtx_state_e     sequencer state encoding
package noise_map_pkg;

    localparam int NOISE_W = 16;
    localparam logic [NOISE_W-1:0] NOISE_PARK_CODE = 16'h7FFF;

    typedef enum logic [2:0] {
        NMTX_IDLE   = 3'd0,
        NMTX_LOAD   = 3'd1,
        NMTX_SETTLE = 3'd2,
        NMTX_MEAS   = 3'd3,
        NMTX_PARK   = 3'd4,
        NMTX_FIN    = 3'd5
    } nmtx_state_e;

endpackage

// File: rtl/noise_map_step.sv
// Next-code / last-point evaluator for a code sweep.
//   cur        code currently applied
//   step       unsigned increment
//   last       final code of the sweep
//   next_code  cur + step (only meaningful when is_last = 0)
//   is_last    cur is the final point: step is zero, cur reached last,
//              or the next step would overshoot last (including 16-bit wrap)
module noise_map_step
    import noise_map_pkg::*;
(
    input  logic [NOISE_W-1:0] cur,
    input  logic [NOISE_W-1:0] step,
    input  logic [NOISE_W-1:0] last,
    output logic [NOISE_W-1:0] next_code,
    output logic               is_last
);

    // One extra bit so a sum past 16'hFFFF compares as larger than any last.
    logic [NOISE_W:0] sum;

    always_comb begin
        sum       = {1'b0, cur} + {1'b0, step};
        next_code = sum[NOISE_W-1:0];
        is_last   = (step == '0) || (cur == last) || (sum > {1'b0, last});
    end

endmodule

// File: rtl/noise_map_tx.sv
// Transmit-side sequencer driving valid/noise_data into the noise map core.
// On start it walks codes cfg_first..cfg_last by cfg_step; each code is held
// with valid for VALID_HOLD cycles, then settles cfg_dwell cycles, then a
// meas_req/meas_ack handshake hands off to the measurement engine.
//   clk, rst_n                 clock, async active-low reset
//   start, abort               one-cycle control pulses
//   cfg_first/last/step/dwell  sweep configuration, captured on start
//   meas_ack                   measurement engine acknowledge
//   valid, noise_data          map core interface
//   meas_req                   level request to measurement engine
//   busy, done, aborted        status (done/aborted are one-cycle pulses)
//   cur_code                   code currently or last applied
module noise_map_tx
    import noise_map_pkg::*;
#(
    parameter int                 VALID_HOLD = 2,
    parameter int                 DWELL_W    = 12,
    parameter logic [NOISE_W-1:0] PARK_CODE  = NOISE_PARK_CODE,
    parameter bit                 RESTORE    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [NOISE_W-1:0] cfg_first,
    input  logic [NOISE_W-1:0] cfg_last,
    input  logic [NOISE_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               meas_ack,
    output logic               valid,
    output logic [NOISE_W-1:0] noise_data,
    output logic               meas_req,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [NOISE_W-1:0] cur_code
);

    localparam int HOLD_W = (VALID_HOLD > 1) ? $clog2(VALID_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(VALID_HOLD - 1);

    nmtx_state_e        state;
    logic [NOISE_W-1:0] sh_last;
    logic [NOISE_W-1:0] sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [NOISE_W-1:0] cur;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DWELL_W-1:0] dwell_cnt;

    logic [NOISE_W-1:0] nxt_code;
    logic               last_pt;

    noise_map_step u_step (
        .cur       (cur),
        .step      (sh_step),
        .last      (sh_last),
        .next_code (nxt_code),
        .is_last   (last_pt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NMTX_IDLE;
            sh_last    <= '0;
            sh_step    <= '0;
            sh_dwell   <= '0;
            cur        <= PARK_CODE;
            hold_cnt   <= '0;
            dwell_cnt  <= '0;
            valid      <= 1'b0;
            noise_data <= PARK_CODE;
            cur_code   <= PARK_CODE;
            meas_req   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // Abort beats everything outside IDLE; noise_data is left as-is so
            // the map core keeps whatever code it last latched.
            if (abort && state != NMTX_IDLE) begin
                state    <= NMTX_IDLE;
                valid    <= 1'b0;
                meas_req <= 1'b0;
                busy     <= 1'b0;
                aborted  <= 1'b1;
            end else begin
                case (state)
                    NMTX_IDLE: begin
                        // start+abort together in IDLE: nothing happens
                        if (start && !abort) begin
                            sh_last    <= cfg_last;
                            sh_step    <= cfg_step;
                            sh_dwell   <= cfg_dwell;
                            cur        <= cfg_first;
                            cur_code   <= cfg_first;
                            noise_data <= cfg_first;
                            valid      <= 1'b1;
                            hold_cnt   <= '0;
                            busy       <= 1'b1;
                            state      <= NMTX_LOAD;
                        end
                    end
                    NMTX_LOAD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            valid <= 1'b0;
                            if (sh_dwell == '0) begin
                                meas_req <= 1'b1;
                                state    <= NMTX_MEAS;
                            end else begin
                                dwell_cnt <= sh_dwell;
                                state     <= NMTX_SETTLE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    NMTX_SETTLE: begin
                        if (dwell_cnt == DWELL_W'(1)) begin
                            meas_req <= 1'b1;
                            state    <= NMTX_MEAS;
                        end else begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end
                    end
                    NMTX_MEAS: begin
                        // Gate on the registered request so a stray ack that
                        // arrives before meas_req is up is ignored.
                        if (meas_req && meas_ack) begin
                            meas_req <= 1'b0;
                            if (last_pt) begin
                                if (RESTORE) begin
                                    valid      <= 1'b1;
                                    noise_data <= PARK_CODE;
                                    cur_code   <= PARK_CODE;
                                    hold_cnt   <= '0;
                                    state      <= NMTX_PARK;
                                end else begin
                                    state <= NMTX_FIN;
                                end
                            end else begin
                                cur        <= nxt_code;
                                cur_code   <= nxt_code;
                                noise_data <= nxt_code;
                                valid      <= 1'b1;
                                hold_cnt   <= '0;
                                state      <= NMTX_LOAD;
                            end
                        end
                    end
                    NMTX_PARK: begin
                        if (hold_cnt == HOLD_LAST) begin
                            valid <= 1'b0;
                            state <= NMTX_FIN;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    NMTX_FIN: begin
                        // done lands together with busy falling
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= NMTX_IDLE;
                    end
                    default: state <= NMTX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noise_map_tx.sv
module tb_noise_map_tx;
    import noise_map_pkg::*;

    localparam int VALID_HOLD = 2;
    localparam int DWELL_W    = 12;
    localparam bit RESTORE    = 1'b1;
    localparam int PARK       = 'h7FFF;

    localparam int EV_CODE  = 0;
    localparam int EV_REQ   = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ABORT = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [15:0]        cfg_first = '0;
    logic [15:0]        cfg_last = '0;
    logic [15:0]        cfg_step = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic               meas_ack = 1'b0;
    logic               valid;
    logic [15:0]        noise_data;
    logic               meas_req;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [15:0]        cur_code;

    noise_map_tx #(
        .VALID_HOLD (VALID_HOLD),
        .DWELL_W    (DWELL_W),
        .PARK_CODE  (16'h7FFF),
        .RESTORE    (RESTORE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_first  (cfg_first),
        .cfg_last   (cfg_last),
        .cfg_step   (cfg_step),
        .cfg_dwell  (cfg_dwell),
        .meas_ack   (meas_ack),
        .valid      (valid),
        .noise_data (noise_data),
        .meas_req   (meas_req),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .cur_code   (cur_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  exp_abort_code = 0;
    int  abort_pt = 0;
    int  resp_cnt = 0;

    function automatic ev_t mk(int k, int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        return e;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic emit(int kind, int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d val %0h expected none", kind, val);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == e.kind && kind == EV_CODE) begin
            chk("code", val, e.val);
            chk("cur_code", cur_code, e.val);
        end
        if (kind == e.kind && kind == EV_REQ) chk("settle_gap", val, e.val);
    endtask

    // Monitor: turns DUT activity into events and checks them against the queue.
    bit prev_valid = 0, prev_req = 0, ack_pend = 0, in_gap = 0;
    int run = 0, run_code = 0, gap = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 0; prev_req = 0; ack_pend = 0; in_gap = 0; run = 0; gap = 0;
        end else begin
            if (ack_pend) chk("req_drop_after_ack", meas_req, 0);
            ack_pend = meas_ack && meas_req;
            if (valid) begin
                if (!prev_valid) begin
                    run = 1; run_code = noise_data; in_gap = 0;
                end else begin
                    run++;
                    if (noise_data != run_code) chk("data_stable", noise_data, run_code);
                end
            end else if (prev_valid) begin
                chk("valid_hold", run, VALID_HOLD);
                emit(EV_CODE, run_code);
                in_gap = 1; gap = 0;
            end
            if (meas_req && !prev_req) begin
                emit(EV_REQ, gap);
                in_gap = 0;
            end else if (in_gap && !meas_req) begin
                gap++;
            end
            if (done) begin
                chk("busy_at_done", busy, 0);
                emit(EV_DONE, 0);
            end
            if (aborted) begin
                chk("abort_busy", busy, 0);
                chk("abort_valid", valid, 0);
                chk("abort_req", meas_req, 0);
                chk("abort_data", noise_data, exp_abort_code);
                emit(EV_ABORT, 0);
            end
            prev_valid = valid;
            prev_req   = meas_req;
        end
    end

    // Measurement engine: random ack latency, occasional stray acks while idle.
    bit resp_prev = 0;
    always begin
        @(posedge clk); #1;
        meas_ack = 1'b0;
        if (!rst_n) begin
            resp_prev = 0; resp_cnt = 0;
        end else begin
            if (!busy) resp_cnt = 0;
            if (meas_req && !resp_prev) resp_cnt++;
            if (meas_req) begin
                if (resp_cnt != abort_pt && $urandom_range(0, 2) == 0) meas_ack = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                meas_ack = 1'b1;
            end
            resp_prev = meas_req;
        end
    end

    // Reference model: list of points from the sweep rules, then scoreboard pushes.
    task automatic sweep(int f, int l, int s, int d, int apt, bit meddle);
        int c, n;
        c = f; n = 0;
        forever begin
            n++;
            exp_q.push_back(mk(EV_CODE, c));
            exp_q.push_back(mk(EV_REQ, d));
            if (apt == n) begin
                exp_abort_code = c;
                exp_q.push_back(mk(EV_ABORT, 0));
                break;
            end
            if (s == 0 || c + s > l) begin
                if (RESTORE) exp_q.push_back(mk(EV_CODE, PARK));
                exp_q.push_back(mk(EV_DONE, 0));
                break;
            end
            c += s;
        end
        abort_pt = apt;
        @(posedge clk); #1;
        cfg_first = 16'(f); cfg_last = 16'(l); cfg_step = 16'(s); cfg_dwell = DWELL_W'(d);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (meddle) begin
            repeat (2) @(posedge clk); #1;
            cfg_first = 16'(f) ^ 16'h0101; cfg_last = 16'($urandom);
            cfg_step = 16'($urandom); cfg_dwell = DWELL_W'($urandom);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (apt > 0) begin
            for (int i = 0; i < 2000 && resp_cnt < apt; i++) begin
                @(posedge clk); #2;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("sweep_complete", exp_q.size(), 0);
        exp_q.delete();
        abort_pt = 0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, s, l, np;
        #12;
        chk("rst_valid", valid, 0);
        chk("rst_data", noise_data, PARK);
        chk("rst_cur", cur_code, PARK);
        chk("rst_req", meas_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        sweep(1, 4, 1, 3, 0, 0);
        sweep('hFFF0, 'hFFFF, 8, 2, 0, 0);
        sweep(10, 20, 0, 1, 0, 0);
        sweep(5, 2, 1, 2, 0, 0);
        sweep('h100, 'h400, 'h100, 2, 2, 0);
        sweep('h20, 'h50, 'h10, 1, 0, 1);
        sweep(3, 9, 3, 0, 0, 0);

        // start+abort together while idle: no events at all
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (8) @(posedge clk); #1;
        chk("idle_sa_busy", busy, 0);
        chk("idle_sa_valid", valid, 0);

        // reset mid-SETTLE
        exp_q.push_back(mk(EV_CODE, 'h1234));
        @(posedge clk); #1;
        cfg_first = 16'h1234; cfg_last = 16'h1234; cfg_step = 16'd1; cfg_dwell = DWELL_W'(20);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("settle_valid", valid, 0);
        chk("settle_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_data", noise_data, PARK);
        chk("arst_cur", cur_code, PARK);
        chk("arst_req", meas_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_queue", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 8; k++) begin
            f  = (k % 3 == 0) ? int'($urandom_range('hFF00, 'hFFFF)) : int'($urandom_range(0, 'hFFFF));
            s  = (k == 5) ? 0 : int'($urandom_range(1, 'h2000));
            np = $urandom_range(1, 5);
            l  = f + s * (np - 1) + ((s > 0) ? int'($urandom_range(0, s - 1)) : 0);
            if (l > 'hFFFF) l = 'hFFFF;
            sweep(f, l, s, $urandom_range(0, 5), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
